// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: hazard-controller state
// encoding, the canonical NOP and the memory-wait timer width.
package riscv_pkg;

  localparam int TIMER_W = 16;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable, saturating count of MEM_WAIT cycles; expired flags count == TIMEOUT.
module mem_wait_timer
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] ONE_C     = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] MAX_C     = '1;

  logic [TIMER_W-1:0] count_q, count_d;

  // NOTE: next-state logic assigns a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = ONE_C;
    end else if (enable && count_q != MAX_C) begin
      count_d = count_q + ONE_C;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TIMEOUT_C);

endmodule

// File: rtl/hazard_controller.sv
// Stall/bubble/flush sequencing for the 5-stage pipeline with a memory watchdog.
// Optional HAZCTRL_PERF_CNT_EN adds stall_cycles / flush_count counters.
module hazard_controller
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_use_rs1,
  input  logic        ifid_use_rs2,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic        branch_taken,
  input  logic        exmem_memreq,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        mem_err
`ifdef HAZCTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  hz_state_e state_q, state_d;
  logic      active_q, active_d;
  logic      hz, expired;
  logic      tmr_clear, tmr_load, tmr_enable;
  logic      freeze, redirect, abort;

  assign hz = idex_memread && (idex_rd != 5'd0) &&
              ((ifid_use_rs1 && ifid_rs1 == idex_rd) ||
               (ifid_use_rs2 && ifid_rs2 == idex_rd));

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .load    (tmr_load),
    .enable  (tmr_enable),
    .expired (expired)
  );

  // active_q keeps the first cycle after reset silent and the FSM parked in RUN.
  always_comb begin
    state_d    = state_q;
    active_d   = 1'b1;
    tmr_clear  = 1'b0;
    tmr_load   = 1'b0;
    tmr_enable = 1'b0;
    freeze     = 1'b0;
    redirect   = 1'b0;
    abort      = 1'b0;
    if (active_q) begin
      unique case (state_q)
        RUN: begin
          if (exmem_memreq && !dmem_ready) begin
            freeze   = 1'b1;
            tmr_load = 1'b1;
            state_d  = MEM_WAIT;
          end else begin
            redirect = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            redirect  = 1'b1;
            tmr_clear = 1'b1;
            state_d   = RUN;
          end else begin
            freeze = 1'b1;
            if (expired) state_d = MEM_ERR;
            else         tmr_enable = 1'b1;
          end
        end
        MEM_ERR: begin
          abort     = 1'b1;
          tmr_clear = 1'b1;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  // A taken branch squashes the dependent instruction, so it masks the load-use stall.
  assign pc_stall     = freeze || (redirect && !branch_taken && hz);
  assign ifid_stall   = pc_stall;
  assign idex_stall   = freeze;
  assign exmem_stall  = freeze;
  assign ifid_flush   = (redirect && branch_taken) || abort;
  assign idex_bubble  = (redirect && (branch_taken || hz)) || abort;
  assign memwb_bubble = freeze || abort;
  assign mem_err      = abort;

`ifdef HAZCTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (pc_stall && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
    if (ifid_flush && flush_count_q != 32'hFFFF_FFFF) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
